instruction_fetch: RTL

//  Fetch stage feeding instruction_decoder: owns the fetch PC, drives the instruction-memory

---
 rtl/instruction_fetch_pkg.sv | 32 +++
 rtl/instruction_fetch_if.sv | 23 ++
 rtl/instruction_fetch_skid_buffer.sv | 34 +++
 rtl/instruction_fetch.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Optional IFETCH_MISALIGN_TRAP_EN adds the StTrap state.
package instruction_fetch_pkg;

   localparam logic [31:0] PcStep   = 32'd4;
   localparam logic [31:0] NopInstr = 32'h0000_0013;

`ifdef IFETCH_MISALIGN_TRAP_EN
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StWait = 3'd1,
      StSkid = 3'd2,
      StDrop = 3'd3,
      StTrap = 3'd4
   } fetch_state_e;
`else
   typedef enum logic [2:0] {
      StIdle = 3'd0,
      StWait = 3'd1,
      StSkid = 3'd2,
      StDrop = 3'd3
   } fetch_state_e;
`endif

   // Next sequential word address; wraps 32'hFFFF_FFFC -> 0 and stays word-aligned.
   function automatic logic [31:0] pc_inc(input logic [31:0] a);
      logic [31:0] sum;
      sum = a + PcStep;
      return {sum[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/ack handshake between the fetch stage and memory.
interface instruction_fetch_if;

   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rdata
   );

endinterface

// File: rtl/instruction_fetch_skid_buffer.sv
// One-entry skid register holding {instruction, address} while decode stalls.
// Flush has priority over load, load over unload.
module instruction_fetch_skid_buffer (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_load,
   input  logic        i_unload,
   input  logic        i_flush,
   input  logic [63:0] i_data,
   output logic        o_valid,
   output logic [63:0] o_data
);

   logic        r_valid;
   logic [63:0] r_data;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_valid <= 1'b0;
         r_data  <= '0;
      end else if (i_flush) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_data  <= i_data;
      end else if (i_unload) begin
         r_valid <= 1'b0;
      end
   end

   assign o_valid = r_valid;
   assign o_data  = r_data;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the fetch PC, drives the imem handshake and holds IR/pc for decode.
// Define IFETCH_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = NopInstr
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   instruction_fetch_if.master        io_imem,
   input  logic                       i_stall,
   input  logic                       i_redirect,
   input  logic [31:0]                i_redirect_pc,
   output logic [31:0]                o_ir,
   output logic [31:0]                o_pc,
   output logic                       o_ir_valid
`ifdef IFETCH_MISALIGN_TRAP_EN
   ,
   output logic                       o_fetch_misaligned
`endif
);

   localparam logic [31:0] ResetAddr = {RESET_PC[31:2], 2'b00};

   fetch_state_e r_state, w_state_nxt;
   logic [31:0]  r_fetch_pc, w_fetch_pc_nxt;
   logic [31:0]  r_imem_addr, w_imem_addr_nxt;
   logic [31:0]  r_ir, w_ir_nxt;
   logic [31:0]  r_pc, w_pc_nxt;
   logic         r_ir_valid, w_ir_valid_nxt;

   logic         w_ack;
   logic         w_slot_free;
   logic         w_outstanding;
   logic [31:0]  w_redir_pc;
   logic         w_skid_load;
   logic         w_skid_unload;
   logic         w_skid_valid;
   logic [63:0]  w_skid_data;

`ifdef IFETCH_MISALIGN_TRAP_EN
   logic         r_misaligned, w_misaligned_nxt;
   logic         r_trap_pend, w_trap_pend_nxt;
   logic         w_redir_bad;

   assign w_redir_bad = |i_redirect_pc[1:0];
   assign w_redir_pc  = i_redirect_pc;
`else
   assign w_redir_pc  = i_redirect_pc & 32'hFFFF_FFFC;
`endif

   assign w_ack         = io_imem.ack;
   assign w_slot_free   = !r_ir_valid || !i_stall;
   // A request is still in flight and must be allowed to complete.
   assign w_outstanding = ((r_state == StWait) || (r_state == StDrop)) && !w_ack;

   instruction_fetch_skid_buffer u_skid (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_load   (w_skid_load),
      .i_unload (w_skid_unload),
      .i_flush  (i_redirect),
      .i_data   ({io_imem.rdata, r_imem_addr}),
      .o_valid  (w_skid_valid),
      .o_data   (w_skid_data)
   );

   always_comb begin
      w_state_nxt     = r_state;
      w_fetch_pc_nxt  = r_fetch_pc;
      w_imem_addr_nxt = r_imem_addr;
      w_ir_nxt        = r_ir;
      w_pc_nxt        = r_pc;
      w_ir_valid_nxt  = r_ir_valid && i_stall;
      w_skid_load     = 1'b0;
      w_skid_unload   = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
      w_misaligned_nxt = r_misaligned;
      w_trap_pend_nxt  = r_trap_pend;
`endif
      if (i_redirect) begin
         w_ir_nxt       = NOP_INSTR;
         w_ir_valid_nxt = 1'b0;
`ifdef IFETCH_MISALIGN_TRAP_EN
         if (w_redir_bad) begin
            w_misaligned_nxt = 1'b1;
            if (w_outstanding) begin
               w_state_nxt     = StDrop;
               w_trap_pend_nxt = 1'b1;
            end else begin
               w_state_nxt     = StTrap;
               w_trap_pend_nxt = 1'b0;
            end
         end else begin
            w_misaligned_nxt = 1'b0;
            w_trap_pend_nxt  = 1'b0;
`endif
            w_fetch_pc_nxt = w_redir_pc;
            if (w_outstanding) begin
               w_state_nxt = StDrop;
            end else begin
               w_state_nxt     = StWait;
               w_imem_addr_nxt = w_redir_pc;
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
         end
`endif
      end else begin
         unique case (r_state)
            StIdle: begin
               w_state_nxt     = StWait;
               w_imem_addr_nxt = r_fetch_pc;
            end
            StWait: begin
               if (w_ack) begin
                  w_imem_addr_nxt = pc_inc(r_imem_addr);
                  if (w_slot_free) begin
                     w_ir_nxt       = io_imem.rdata;
                     w_pc_nxt       = r_imem_addr;
                     w_ir_valid_nxt = 1'b1;
                  end else begin
                     w_skid_load = 1'b1;
                     w_state_nxt = StSkid;
                  end
               end
            end
            StSkid: begin
               if (!i_stall && w_skid_valid) begin
                  w_ir_nxt       = w_skid_data[63:32];
                  w_pc_nxt       = w_skid_data[31:0];
                  w_ir_valid_nxt = 1'b1;
                  w_skid_unload  = 1'b1;
                  w_state_nxt    = StWait;
               end
            end
            StDrop: begin
               if (w_ack) begin
`ifdef IFETCH_MISALIGN_TRAP_EN
                  if (r_trap_pend) begin
                     w_state_nxt     = StTrap;
                     w_trap_pend_nxt = 1'b0;
                  end else begin
                     w_state_nxt     = StWait;
                     w_imem_addr_nxt = r_fetch_pc;
                  end
`else
                  w_state_nxt     = StWait;
                  w_imem_addr_nxt = r_fetch_pc;
`endif
               end
            end
`ifdef IFETCH_MISALIGN_TRAP_EN
            StTrap: w_state_nxt = StTrap;
`endif
            default: w_state_nxt = StIdle;
         endcase
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_state     <= StIdle;
         r_fetch_pc  <= ResetAddr;
         r_imem_addr <= ResetAddr;
         r_ir        <= NOP_INSTR;
         r_pc        <= RESET_PC;
         r_ir_valid  <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_fetch_pc  <= w_fetch_pc_nxt;
         r_imem_addr <= w_imem_addr_nxt;
         r_ir        <= w_ir_nxt;
         r_pc        <= w_pc_nxt;
         r_ir_valid  <= w_ir_valid_nxt;
      end
   end

`ifdef IFETCH_MISALIGN_TRAP_EN
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_misaligned <= 1'b0;
         r_trap_pend  <= 1'b0;
      end else begin
         r_misaligned <= w_misaligned_nxt;
         r_trap_pend  <= w_trap_pend_nxt;
      end
   end

   assign o_fetch_misaligned = r_misaligned;
`endif

   assign io_imem.req  = (r_state == StWait) || (r_state == StDrop);
   assign io_imem.addr = r_imem_addr;
   assign o_ir         = r_ir;
   assign o_pc         = r_pc;
   assign o_ir_valid   = r_ir_valid;

endmodule
